// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
// Bundles the signals between the four game-side byte producers, the
// transmit scheduler and the uart TX FIFO write port.
//   data_game_state_sel : producer 0 byte
//   data_gloves_control : producer 1 byte
//   data_mouse_control  : producer 2 byte
//   data_score_control  : producer 3 byte
//   tx_full             : uart TX FIFO full flag
//   w_data              : byte written into the uart TX FIFO
//   wr_uart             : one-cycle FIFO write strobe
//   pending             : per-producer pending flags (debug)
// modport master : the scheduler side (drives the FIFO write port)
// modport slave  : the producers / uart side
interface uart_tx_scheduler_if;
  logic [7:0] data_game_state_sel;
  logic [7:0] data_gloves_control;
  logic [7:0] data_mouse_control;
  logic [7:0] data_score_control;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [3:0] pending;

  modport master (
    input  data_game_state_sel,
    input  data_gloves_control,
    input  data_mouse_control,
    input  data_score_control,
    input  tx_full,
    output w_data,
    output wr_uart,
    output pending
  );

  modport slave (
    output data_game_state_sel,
    output data_gloves_control,
    output data_mouse_control,
    output data_score_control,
    output tx_full,
    input  w_data,
    input  wr_uart,
    input  pending
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares the single uart TX FIFO write port between four byte producers.
// A producer whose byte changes gets one pending send (latest value wins);
// every REFRESH_CYCLES clocks all four bytes are re-queued as a keep-alive.
// Pending producers are granted round-robin, one byte per three cycles,
// and no grant is made while the FIFO reports full.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_tx_scheduler_if.master (producer bytes, tx_full in;
//         w_data, wr_uart, pending out)
module uart_tx_scheduler #(
  parameter int REFRESH_CYCLES = 6_500_000,
  parameter int CNT_W          = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       w_din    [4];
  logic [7:0]       r_prev   [4];
  logic [7:0]       r_shadow [4];
  logic [3:0]       r_pending;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_wdata;
  logic             r_wr;

  logic             w_refresh;
  logic [3:0]       w_changed;
  logic [3:0]       w_set;
  logic [3:0]       w_clr;
  logic             w_grant_vld;
  logic [1:0]       w_grant_idx;

  // Round-robin search: first pending producer at ptr, ptr+1, ... mod 4.
  // Walking the offsets from the far end lets the nearest one win.
  function automatic logic [1:0] find_grant(input logic [3:0] pend,
                                            input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (pend[cand]) idx = cand;
    end
    return idx;
  endfunction

  assign w_din[0] = bus.data_game_state_sel;
  assign w_din[1] = bus.data_gloves_control;
  assign w_din[2] = bus.data_mouse_control;
  assign w_din[3] = bus.data_score_control;

  assign w_refresh = (r_cnt == CNT_W'(REFRESH_CYCLES - 1));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_changed[i] = (w_din[i] != r_prev[i]);
    end
  end

  // A change or refresh in the grant cycle re-arms the flag (set wins).
  assign w_set = w_changed | {4{w_refresh}};
  assign w_clr = w_grant_vld ? (4'b0001 << w_grant_idx) : 4'b0000;

  // FSM next state and grant decision; tx_full only matters in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if ((|r_pending) && !bus.tx_full) begin
          w_grant_vld = 1'b1;
          w_grant_idx = find_grant(r_pending, r_ptr);
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: w_state_nxt = ST_WAIT;
      // Gap cycle so tx_full can reflect the write just made.
      ST_WAIT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_prev[i]   <= 8'h00;
        r_shadow[i] <= 8'h00;
      end
      r_pending <= 4'b0000;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
      r_wdata   <= 8'h00;
      r_wr      <= 1'b0;
    end else begin
      // Strobe is high only in the cycle after a grant (the SEND state).
      r_wr <= w_grant_vld;
      if (w_grant_vld) begin
        r_wdata <= r_shadow[w_grant_idx];
        r_ptr   <= w_grant_idx + 2'd1;
      end

      r_pending <= (r_pending & ~w_clr) | w_set;

      for (int i = 0; i < 4; i++) begin
        if (w_changed[i]) r_prev[i] <= w_din[i];
        if (w_changed[i] || w_refresh) r_shadow[i] <= w_din[i];
      end

      r_cnt <= w_refresh ? '0 : r_cnt + 1'b1;
    end
  end

  assign bus.w_data  = r_wdata;
  assign bus.wr_uart = r_wr;
  assign bus.pending = r_pending;

endmodule
